// File: rtl/frame_loader.sv
// frame_loader: hunts for a sync byte, buffers one payload frame,
// verifies its XOR checksum and burst-writes it into parameter memory.
module frame_loader #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         PAYLOAD_LEN = 6,
    parameter int         ADDR_W      = 3,
    parameter int         TIMEOUT_CYC = 1000,
    parameter int         TO_W        = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [7:0]        i_Rx_Byte,
    input  logic              i_Rx_DV,
    output logic [7:0]        o_Mem_Data,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic              o_Mem_Write,
    output logic              o_Frame_Done,
    output logic              o_Frame_Err,
    output logic [1:0]        o_Err_Code,
    output logic              o_Busy
);

    // idx needs one extra bit so it can reach PAYLOAD_LEN == 2**ADDR_W
    localparam int IW = ADDR_W + 1;
    localparam logic [IW-1:0] LEN_C = IW'(PAYLOAD_LEN);
    localparam logic [IW-1:0] LAST_C = IW'(PAYLOAD_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_CSUM = 2'b01;
    localparam logic [1:0] ERR_TOUT = 2'b10;
    localparam logic [1:0] ERR_OVRN = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        COMMIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0] frame_buf [PAYLOAD_LEN];
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic [7:0] csum;
    logic [7:0] csum_nxt;
    logic [TO_W-1:0] timer;
    logic [TO_W-1:0] timer_nxt;
    logic buf_we;

    logic [7:0] data_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic write_nxt;
    logic done_nxt;
    logic err_nxt;
    logic [1:0] code_nxt;

    // Next-state, datapath and next-output decode
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        csum_nxt  = csum;
        timer_nxt = timer;
        buf_we    = 1'b0;
        data_nxt  = '0;
        addr_nxt  = '0;
        write_nxt = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = o_Err_Code;

        unique case (state)
            IDLE: begin
                if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                    state_nxt = PAYLOAD;
                    idx_nxt   = '0;
                    csum_nxt  = '0;
                    timer_nxt = '0;
                end
            end
            PAYLOAD: begin
                if (i_Rx_DV) begin
                    buf_we    = 1'b1;
                    csum_nxt  = csum ^ i_Rx_Byte;
                    idx_nxt   = idx + 1'b1;
                    timer_nxt = '0;
                    if (idx == LAST_C) begin
                        state_nxt = CHECK;
                    end
                end else if (timer == TO_LAST) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_TOUT;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            CHECK: begin
                if (i_Rx_DV) begin
                    timer_nxt = '0;
                    if (i_Rx_Byte == csum) begin
                        // first write of the burst leaves with this edge
                        state_nxt = COMMIT;
                        write_nxt = 1'b1;
                        addr_nxt  = '0;
                        data_nxt  = frame_buf[0];
                        idx_nxt   = {{(IW-1){1'b0}}, 1'b1};
                    end else begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_CSUM;
                        state_nxt = IDLE;
                    end
                end else if (timer == TO_LAST) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_TOUT;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            COMMIT: begin
                // a byte arriving mid-burst is dropped but reported
                if (i_Rx_DV) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_OVRN;
                end
                if (idx == LEN_C) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    write_nxt = 1'b1;
                    addr_nxt  = idx[ADDR_W-1:0];
                    data_nxt  = frame_buf[idx[ADDR_W-1:0]];
                    idx_nxt   = idx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state        <= IDLE;
            idx          <= '0;
            csum         <= '0;
            timer        <= '0;
            o_Mem_Data   <= '0;
            o_Mem_Addr   <= '0;
            o_Mem_Write  <= 1'b0;
            o_Frame_Done <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Err_Code   <= '0;
            o_Busy       <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            csum         <= csum_nxt;
            timer        <= timer_nxt;
            o_Mem_Data   <= data_nxt;
            o_Mem_Addr   <= addr_nxt;
            o_Mem_Write  <= write_nxt;
            o_Frame_Done <= done_nxt;
            o_Frame_Err  <= err_nxt;
            o_Err_Code   <= code_nxt;
            o_Busy       <= (state_nxt != IDLE);
        end
    end

    // Payload buffer capture
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < PAYLOAD_LEN; i++) begin
                frame_buf[i] <= '0;
            end
        end else if (buf_we) begin
            frame_buf[idx[ADDR_W-1:0]] <= i_Rx_Byte;
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: vector table, hand-timed corner cases and random
// frames checked against a frame-level reference model.
module tb_frame_loader;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L;
    logic [7:0] i_Rx_Byte;
    logic       i_Rx_DV;
    logic [7:0] o_Mem_Data;
    logic [2:0] o_Mem_Addr;
    logic       o_Mem_Write;
    logic       o_Frame_Done;
    logic       o_Frame_Err;
    logic [1:0] o_Err_Code;
    logic       o_Busy;

    frame_loader dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Rx_Byte    (i_Rx_Byte),
        .i_Rx_DV      (i_Rx_DV),
        .o_Mem_Data   (o_Mem_Data),
        .o_Mem_Addr   (o_Mem_Addr),
        .o_Mem_Write  (o_Mem_Write),
        .o_Frame_Done (o_Frame_Done),
        .o_Frame_Err  (o_Frame_Err),
        .o_Err_Code   (o_Err_Code),
        .o_Busy       (o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    // external parameter memory and event counters
    logic [7:0] mem [8] = '{default: 8'h00};
    int n_wr = 0;
    int n_done = 0;
    int n_err = 0;
    int n_stray = 0;

    always @(negedge i_Clk) begin
        if (o_Mem_Write) begin
            mem[o_Mem_Addr] <= o_Mem_Data;
            n_wr <= n_wr + 1;
            if (!o_Busy) n_stray <= n_stray + 1;
        end
        if (o_Frame_Done) n_done <= n_done + 1;
        if (o_Frame_Err) n_err <= n_err + 1;
    end

    int n_chk = 0;
    int n_pass = 0;
    int b_wr, b_done, b_err;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_Rx_Byte = b;
        i_Rx_DV = 1'b1;
        tick();
        i_Rx_DV = 1'b0;
    endtask

    task automatic snap();
        b_wr = n_wr;
        b_done = n_done;
        b_err = n_err;
    endtask

    function automatic logic [47:0] mem_pack();
        return {mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]};
    endfunction

    typedef struct {
        logic [79:0] bytes;
        int n;
        int wr;
        int done;
        int err;
        logic [1:0] code;
        logic [47:0] mem;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] mdl [6];
    logic [1:0] mdl_code;
    logic [7:0] pay [6];
    logic [7:0] x;
    logic [7:0] ck;
    bit good;

    initial begin
        tbl[0] = '{80'h00FF_A501020304050607, 10, 6, 1, 0, 2'b00,
                   48'h060504030201};
        tbl[1] = '{80'hA501020304050608_0000, 8, 0, 0, 1, 2'b01,
                   48'h060504030201};
        tbl[2] = '{80'hA5A5A5A5A5A5A500_0000, 8, 6, 1, 0, 2'b01,
                   48'hA5A5A5A5A5A5};
        tbl[3] = '{80'hA510203040506070_0000, 8, 6, 1, 0, 2'b01,
                   48'h605040302010};
        tbl[4] = '{80'hA5FF00FF00FF00FF_0000, 8, 6, 1, 0, 2'b01,
                   48'h00FF00FF00FF};
        tbl[5] = '{80'hA5FF00FF00FF0000_0000, 8, 0, 0, 1, 2'b01,
                   48'h00FF00FF00FF};

        i_Rst_L = 1'b0;
        i_Rx_DV = 1'b0;
        i_Rx_Byte = 8'h00;
        repeat (3) tick();
        check("reset_outputs",
              {o_Mem_Data, o_Mem_Addr, o_Mem_Write, o_Frame_Done,
               o_Frame_Err, o_Err_Code, o_Busy}, 64'h0);
        i_Rst_L = 1'b1;
        tick();

        // table-driven frames, one idle cycle between bytes
        for (int t = 0; t < 6; t++) begin
            snap();
            for (int i = 0; i < tbl[t].n; i++) begin
                send(tbl[t].bytes[79-8*i -: 8]);
                tick();
            end
            repeat (12) tick();
            check($sformatf("vec%0d_writes", t), n_wr - b_wr, tbl[t].wr);
            check($sformatf("vec%0d_done", t), n_done - b_done, tbl[t].done);
            check($sformatf("vec%0d_err", t), n_err - b_err, tbl[t].err);
            check($sformatf("vec%0d_code", t), o_Err_Code, tbl[t].code);
            check($sformatf("vec%0d_mem", t), mem_pack(), tbl[t].mem);
        end

        // exact burst timing, then a sync in the Done cycle
        snap();
        send(8'hA5);
        for (int i = 1; i <= 6; i++) send(8'(i));
        send(8'h07);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t1_write%0d", i),
                  {o_Mem_Write, o_Mem_Addr, o_Mem_Data, o_Frame_Done},
                  {1'b1, 3'(i), 8'(i + 1), 1'b0});
            tick();
        end
        check("t1_done_cycle",
              {o_Frame_Done, o_Busy, o_Mem_Write}, {1'b1, 1'b0, 1'b0});
        send(8'hA5);
        send(8'h0A); send(8'h0B); send(8'h0C);
        send(8'h0D); send(8'h0E); send(8'h0F);
        send(8'h01);
        repeat (12) tick();
        check("t6_done_count", n_done - b_done, 2);
        check("t6_writes", n_wr - b_wr, 12);
        check("t6_mem", mem_pack(), 48'h0F0E0D0C0B0A);

        // timeout: byte on the expiring cycle wins, full gap expires
        snap();
        send(8'hA5); send(8'h11); send(8'h22);
        repeat (999) tick();
        check("t3_no_err_999", n_err - b_err, 0);
        send(8'h33);
        check("t3_expiring_dv", {o_Frame_Err, o_Busy}, {1'b0, 1'b1});
        repeat (999) tick();
        check("t3_no_err_yet", {o_Frame_Err, o_Busy}, {1'b0, 1'b1});
        tick();
        check("t3_timeout",
              {o_Frame_Err, o_Err_Code, o_Busy}, {1'b1, 2'b10, 1'b0});
        tick();
        check("t3_err_pulse", {o_Frame_Err, o_Err_Code}, {1'b0, 2'b10});

        // overrun during the burst
        snap();
        send(8'hA5);
        send(8'h21); send(8'h22); send(8'h23);
        send(8'h24); send(8'h25); send(8'h26);
        send(8'h07);
        tick();
        send(8'hAA);
        check("t4_overrun",
              {o_Frame_Err, o_Err_Code, o_Mem_Write, o_Mem_Addr},
              {1'b1, 2'b11, 1'b1, 3'd2});
        repeat (12) tick();
        check("t4_writes", n_wr - b_wr, 6);
        check("t4_done", n_done - b_done, 1);
        check("t4_err", n_err - b_err, 1);
        check("t4_mem", mem_pack(), 48'h262524232221);

        // reset after three writes
        snap();
        send(8'hA5);
        send(8'h31); send(8'h32); send(8'h33);
        send(8'h34); send(8'h35); send(8'h36);
        send(8'h07);
        tick();
        tick();
        check("t5_third_write", {o_Mem_Write, o_Mem_Addr}, {1'b1, 3'd2});
        i_Rst_L = 1'b0;
        tick();
        check("t5_reset_outputs",
              {o_Mem_Data, o_Mem_Addr, o_Mem_Write, o_Frame_Done,
               o_Frame_Err, o_Err_Code, o_Busy}, 64'h0);
        tick();
        i_Rst_L = 1'b1;
        repeat (10) tick();
        check("t5_writes", n_wr - b_wr, 3);
        check("t5_done", n_done - b_done, 0);
        check("t5_mem", mem_pack(), 48'h262524333231);

        // random frames against a frame-level model
        mdl = '{8'h31, 8'h32, 8'h33, 8'h24, 8'h25, 8'h26};
        mdl_code = 2'b00;
        for (int f = 0; f < 40; f++) begin
            snap();
            repeat ($urandom_range(0, 2)) begin
                x = 8'($urandom_range(0, 255));
                if (x == 8'hA5) x = 8'h5A;
                send(x);
                repeat ($urandom_range(0, 2)) tick();
            end
            send(8'hA5);
            ck = 8'h00;
            for (int i = 0; i < 6; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                pay[i] = ($urandom_range(0, 7) == 0) ? 8'hA5
                         : 8'($urandom_range(0, 255));
                ck = ck ^ pay[i];
                send(pay[i]);
            end
            good = ($urandom_range(0, 3) != 0);
            x = good ? ck : (ck ^ 8'($urandom_range(1, 255)));
            repeat ($urandom_range(0, 3)) tick();
            send(x);
            repeat (10) tick();
            if (good) begin
                for (int i = 0; i < 6; i++) mdl[i] = pay[i];
            end else begin
                mdl_code = 2'b01;
            end
            check($sformatf("rnd%0d_events", f),
                  {32'(n_done - b_done), 32'(n_err - b_err)},
                  {32'(good ? 1 : 0), 32'(good ? 0 : 1)});
            check($sformatf("rnd%0d_code", f), o_Err_Code, mdl_code);
            check($sformatf("rnd%0d_mem", f), mem_pack(),
                  {mdl[5], mdl[4], mdl[3], mdl[2], mdl[1], mdl[0]});
        end

        check("strobe_outside_busy", n_stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
